// File: rtl/pipeline_stall_sequencer_if.sv
// Control bundle between the pipeline datapath and the stall/flush sequencer.
// The datapath (master) raises stall/flush requests; the sequencer (slave)
// answers with register enables, bubbles, the mult/div start pulse and stats.
interface pipeline_stall_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             load_use_hazard;
    logic             branch_taken;
    logic             md_start;
    logic             mf_hilo_use;
    logic             mem_access;
    logic             dmem_ready;
    logic             stat_clear;
    logic             pc_write_en;
    logic             if_id_write_en;
    logic             if_id_flush;
    logic             id_ex_write_en;
    logic             id_ex_bubble;
    logic             ex_mem_write_en;
    logic             mem_wb_bubble;
    logic             md_go;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output load_use_hazard, branch_taken, md_start, mf_hilo_use,
               mem_access, dmem_ready, stat_clear,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
               id_ex_bubble, ex_mem_write_en, mem_wb_bubble, md_go, md_busy,
               stall_cycles
    );

    modport slave (
        input  load_use_hazard, branch_taken, md_start, mf_hilo_use,
               mem_access, dmem_ready, stat_clear,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
               id_ex_bubble, ex_mem_write_en, mem_wb_bubble, md_go, md_busy,
               stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline. Resolves, in priority
// order, data-memory freeze, taken-branch flush and ID stalls (load-use or a
// mult/div dependency), launches the iterative mult/div unit and tracks its
// busy window, and keeps a saturating count of cycles in which the PC held.
module pipeline_stall_sequencer #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    pipeline_stall_sequencer_if.slave  bus
);
    localparam int unsigned MD_W = $clog2(MD_LATENCY + 1);

    logic [MD_W-1:0]  md_cnt;
    logic [CNT_W-1:0] stall_cnt;

    logic freeze;
    logic flush;
    logic stall;
    logic busy;
    logic go;
    logic pc_we;

    // Classify the cycle by priority and derive the mult/div launch condition.
    always_comb begin
        busy   = (md_cnt != '0);
        freeze = bus.mem_access & ~bus.dmem_ready;
        flush  = bus.branch_taken & ~freeze;
        stall  = (bus.load_use_hazard | (busy & (bus.md_start | bus.mf_hilo_use)))
                 & ~freeze & ~flush;
        go     = bus.md_start & ~busy & ~freeze & ~flush & ~bus.load_use_hazard;
    end

    // Drive the pipeline controls; reset forces every stage to hold or bubble.
    always_comb begin
        bus.pc_write_en     = 1'b1;
        bus.if_id_write_en  = 1'b1;
        bus.if_id_flush     = 1'b0;
        bus.id_ex_write_en  = 1'b1;
        bus.id_ex_bubble    = 1'b0;
        bus.ex_mem_write_en = 1'b1;
        bus.mem_wb_bubble   = 1'b0;
        bus.md_go           = go;
        bus.md_busy         = busy;
        if (!reset) begin
            bus.pc_write_en     = 1'b0;
            bus.if_id_write_en  = 1'b0;
            bus.if_id_flush     = 1'b1;
            bus.id_ex_write_en  = 1'b0;
            bus.id_ex_bubble    = 1'b1;
            bus.ex_mem_write_en = 1'b0;
            bus.mem_wb_bubble   = 1'b1;
            bus.md_go           = 1'b0;
            bus.md_busy         = 1'b0;
        end else if (freeze) begin
            bus.pc_write_en     = 1'b0;
            bus.if_id_write_en  = 1'b0;
            bus.id_ex_write_en  = 1'b0;
            bus.ex_mem_write_en = 1'b0;
            bus.mem_wb_bubble   = 1'b1;
        end else if (flush) begin
            bus.if_id_flush     = 1'b1;
            bus.id_ex_bubble    = 1'b1;
        end else if (stall) begin
            bus.pc_write_en     = 1'b0;
            bus.if_id_write_en  = 1'b0;
            bus.id_ex_bubble    = 1'b1;
        end
    end

    always_comb begin
        pc_we            = bus.pc_write_en;
        bus.stall_cycles = stall_cnt;
    end

    // Mult/div busy window: load on launch, count down every cycle (even when frozen).
    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (go) begin
            md_cnt <= MD_W'(MD_LATENCY);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    // Saturating count of cycles where the PC did not advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (bus.stat_clear) begin
            stall_cnt <= '0;
        end else if (!pc_we && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule
